udp_status_sender: RTL and testbench



---
 rtl/udp_status_pkg.sv | 44 ++++
 rtl/udp_status_sender.sv | 141 ++++++++++++++
 tb/tb_udp_status_sender.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_status_pkg.sv
// Shared definitions for the UDP status reply path (sender and poll decoder).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package udp_status_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int PAYLOAD_WORDS = 4;
    localparam int PAYLOAD_BYTES = 16;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4C454443;  // "LEDC"

    // Word positions inside the reply payload
    localparam logic [1:0] W_MAGIC  = 2'd0;
    localparam logic [1:0] W_STATUS = 2'd1;
    localparam logic [1:0] W_FRAME  = 2'd2;
    localparam logic [1:0] W_RXPKT  = 2'd3;

    // Counters and flags frozen when a reply starts
    typedef struct packed {
        logic [15:0] sent;
        logic [15:0] flags;
        logic [31:0] frame;
        logic [31:0] rx;
    } snap_t;

    // Payload word for a given beat index, built only from the snapshot
    function automatic logic [31:0] payload_word(input logic [1:0]  idx,
                                                 input logic [31:0] magic,
                                                 input snap_t       s);
        logic [31:0] w;
        case (idx)
            W_MAGIC:  w = magic;
            W_STATUS: w = {s.sent, s.flags};
            W_FRAME:  w = s.frame;
            default:  w = s.rx;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/udp_status_sender.sv
// Builds 4-word UDP status replies to the last requester and streams them to the core.
// Latency: req in IDLE at cycle N -> word 0 valid at N+1; back-to-back replies every 5 cycles minimum.
// Backpressure: beats held stable while ready=0; requests arriving while busy coalesce into one pending reply.
module udp_status_sender
    import udp_status_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'd6000,
    parameter logic [31:0] MAGIC      = DEFAULT_MAGIC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    input  logic [31:0] frame_count,
    input  logic [31:0] rx_packet_count,
    input  logic [15:0] status_flags,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,
    output logic [3:0]  udp_sink_error,
    output logic        busy,
    output logic [15:0] sent_count
);

    state_t      state_q,     state_d;
    logic [1:0]  idx_q,       idx_d;
    snap_t       snap_q,      snap_d;
    logic [15:0] dst_port_q,  dst_port_d;
    logic [31:0] ip_q,        ip_d;
    logic        pend_vld_q,  pend_vld_d;
    logic [15:0] pend_port_q, pend_port_d;
    logic [31:0] pend_ip_q,   pend_ip_d;
    logic [15:0] sent_count_q, sent_count_d;
    logic [31:0] data_q,      data_d;
    logic        last_q,      last_d;

    // Next-state, snapshot, pending-request and output-word logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        dst_port_d   = dst_port_q;
        ip_d         = ip_q;
        pend_vld_d   = pend_vld_q;
        pend_port_d  = pend_port_q;
        pend_ip_d    = pend_ip_q;
        sent_count_d = sent_count_q;
        data_d       = data_q;
        last_d       = last_q;

        case (state_q)
            ST_IDLE: begin
                if (req || pend_vld_q) begin
                    state_d    = ST_SEND;
                    idx_d      = W_MAGIC;
                    // A fresh request overrides whatever was pending
                    dst_port_d = req ? req_port : pend_port_q;
                    ip_d       = req ? req_ip   : pend_ip_q;
                    pend_vld_d = 1'b0;
                    snap_d     = '{sent:  sent_count_q,
                                   flags: status_flags,
                                   frame: frame_count,
                                   rx:    rx_packet_count};
                    data_d     = payload_word(W_MAGIC, MAGIC, snap_d);
                    last_d     = 1'b0;
                end
            end
            ST_SEND: begin
                // Requests during a reply collapse into one follow-up, latest address wins
                if (req) begin
                    pend_vld_d  = 1'b1;
                    pend_port_d = req_port;
                    pend_ip_d   = req_ip;
                end
                if (udp_sink_ready) begin
                    if (idx_q == W_RXPKT) begin
                        state_d      = ST_IDLE;
                        idx_d        = W_MAGIC;
                        sent_count_d = sent_count_q + 16'd1;
                        data_d       = '0;
                        last_d       = 1'b0;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = payload_word(idx_d, MAGIC, snap_q);
                        last_d = (idx_d == W_RXPKT);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any packet in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= W_MAGIC;
            snap_q       <= '0;
            dst_port_q   <= '0;
            ip_q         <= '0;
            pend_vld_q   <= 1'b0;
            pend_port_q  <= '0;
            pend_ip_q    <= '0;
            sent_count_q <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            dst_port_q   <= dst_port_d;
            ip_q         <= ip_d;
            pend_vld_q   <= pend_vld_d;
            pend_port_q  <= pend_port_d;
            pend_ip_q    <= pend_ip_d;
            sent_count_q <= sent_count_d;
            data_q       <= data_d;
            last_q       <= last_d;
        end
    end

    assign udp_sink_valid      = (state_q == ST_SEND);
    assign busy                = (state_q == ST_SEND);
    assign udp_sink_last       = last_q;
    assign udp_sink_data       = data_q;
    assign udp_sink_dst_port   = dst_port_q;
    assign udp_sink_ip_address = ip_q;
    assign udp_sink_src_port   = LOCAL_PORT;
    assign udp_sink_length     = 16'(PAYLOAD_BYTES);
    assign udp_sink_error      = 4'd0;
    assign sent_count          = sent_count_q;

endmodule

// File: tb/tb_udp_status_sender.sv
module tb_udp_status_sender;

    localparam logic [31:0] MAGIC = 32'h4C454443;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] port;
        logic [31:0] ip;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] req_ip;
    logic [15:0] req_port;
    logic [31:0] frame_count;
    logic [31:0] rx_packet_count;
    logic [15:0] status_flags;
    logic        udp_sink_valid;
    logic        udp_sink_last;
    logic        udp_sink_ready;
    logic [15:0] udp_sink_src_port;
    logic [15:0] udp_sink_dst_port;
    logic [31:0] udp_sink_ip_address;
    logic [15:0] udp_sink_length;
    logic [31:0] udp_sink_data;
    logic [3:0]  udp_sink_error;
    logic        busy;
    logic [15:0] sent_count;

    int    checks = 0;
    int    errors = 0;
    int    vcnt   = 0;
    beat_t exp_q[$];
    logic [15:0] m_sent = 16'd0;

    udp_status_sender dut (
        .clock               (clock),
        .reset               (reset),
        .req                 (req),
        .req_ip              (req_ip),
        .req_port            (req_port),
        .frame_count         (frame_count),
        .rx_packet_count     (rx_packet_count),
        .status_flags        (status_flags),
        .udp_sink_valid      (udp_sink_valid),
        .udp_sink_last       (udp_sink_last),
        .udp_sink_ready      (udp_sink_ready),
        .udp_sink_src_port   (udp_sink_src_port),
        .udp_sink_dst_port   (udp_sink_dst_port),
        .udp_sink_ip_address (udp_sink_ip_address),
        .udp_sink_length     (udp_sink_length),
        .udp_sink_data       (udp_sink_data),
        .udp_sink_error      (udp_sink_error),
        .busy                (busy),
        .sent_count          (sent_count)
    );

    always #5 clock = ~clock;

    // Monitor: pops the scoreboard on each accepted beat and checks stall stability
    logic  hold_vld = 1'b0;
    beat_t hold;
    always @(negedge clock) begin
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                checks++;
                if (udp_sink_data !== hold.data || udp_sink_last !== hold.last ||
                    udp_sink_dst_port !== hold.port || udp_sink_ip_address !== hold.ip) begin
                    errors++;
                    $display("FAIL stall_stable: got data=%h last=%b port=%h ip=%h, held data=%h last=%b port=%h ip=%h",
                             udp_sink_data, udp_sink_last, udp_sink_dst_port, udp_sink_ip_address,
                             hold.data, hold.last, hold.port, hold.ip);
                end
            end
            if (udp_sink_valid) vcnt++;
            if (udp_sink_valid && udp_sink_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: data=%h with empty scoreboard", udp_sink_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (udp_sink_data !== e.data) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h", udp_sink_data, e.data);
                    end
                    checks++;
                    if (udp_sink_last !== e.last) begin
                        errors++;
                        $display("FAIL beat_last: got %b expected %b (data %h)", udp_sink_last, e.last, e.data);
                    end
                    checks++;
                    if (udp_sink_dst_port !== e.port) begin
                        errors++;
                        $display("FAIL beat_port: got %h expected %h", udp_sink_dst_port, e.port);
                    end
                    checks++;
                    if (udp_sink_ip_address !== e.ip) begin
                        errors++;
                        $display("FAIL beat_ip: got %h expected %h", udp_sink_ip_address, e.ip);
                    end
                end
            end
            hold_vld  = udp_sink_valid && !udp_sink_ready;
            hold.data = udp_sink_data;
            hold.last = udp_sink_last;
            hold.port = udp_sink_dst_port;
            hold.ip   = udp_sink_ip_address;
        end
    end

    task automatic push_pkt(input logic [31:0] ip, input logic [15:0] port,
                            input logic [15:0] snt, input logic [15:0] flg,
                            input logic [31:0] frm, input logic [31:0] rx);
        exp_q.push_back('{data: MAGIC,        last: 1'b0, port: port, ip: ip});
        exp_q.push_back('{data: {snt, flg},   last: 1'b0, port: port, ip: ip});
        exp_q.push_back('{data: frm,          last: 1'b0, port: port, ip: ip});
        exp_q.push_back('{data: rx,           last: 1'b1, port: port, ip: ip});
    endtask

    // Request sampled at the next edge N; returns just after N with word 0 visible
    task automatic pulse_req(input logic [31:0] ip, input logic [15:0] port);
        @(posedge clock); #1;
        req      = 1'b1;
        req_ip   = ip;
        req_port = port;
        @(posedge clock); #1;
        req      = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, busy=%b", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (udp_sink_valid !== 1'b0 || udp_sink_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b last=%b busy=%b, expected 0 0 0", udp_sink_valid, udp_sink_last, busy);
        end
        checks++;
        if (udp_sink_data !== 32'd0 || udp_sink_dst_port !== 16'd0 || udp_sink_ip_address !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h port=%h ip=%h, expected zeros", udp_sink_data, udp_sink_dst_port, udp_sink_ip_address);
        end
        checks++;
        if (sent_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_sent: got %h expected 0000", sent_count);
        end
        checks++;
        if (udp_sink_src_port !== 16'd6000 || udp_sink_length !== 16'd16 || udp_sink_error !== 4'd0) begin
            errors++;
            $display("FAIL const_fields: src=%0d len=%0d err=%h, expected 6000 16 0", udp_sink_src_port, udp_sink_length, udp_sink_error);
        end
        m_sent = 16'd0;
    endtask

    task automatic test_basic;
        status_flags    = 16'hA5A5;
        frame_count     = 32'h11223344;
        rx_packet_count = 32'h55667788;
        push_pkt(32'hC0A80164, 16'h1234, m_sent, 16'hA5A5, 32'h11223344, 32'h55667788);
        pulse_req(32'hC0A80164, 16'h1234);
        checks++;
        if (udp_sink_valid !== 1'b1 || udp_sink_data !== MAGIC) begin
            errors++;
            $display("FAIL first_beat_latency: valid=%b data=%h, expected 1 %h", udp_sink_valid, udp_sink_data, MAGIC);
        end
        wait_idle(50);
        m_sent = m_sent + 16'd1;
        checks++;
        if (sent_count !== m_sent) begin
            errors++;
            $display("FAIL basic_sent: got %0d expected %0d", sent_count, m_sent);
        end
    endtask

    task automatic test_backpressure;
        logic pat [10];
        int   v0;
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        frame_count     = 32'hDEAD0001;
        rx_packet_count = 32'hBEEF0002;
        status_flags    = 16'h0F0F;
        push_pkt(32'h0A000001, 16'h4000, m_sent, 16'h0F0F, 32'hDEAD0001, 32'hBEEF0002);
        v0 = vcnt;
        pulse_req(32'h0A000001, 16'h4000);
        udp_sink_ready = pat[0];
        for (int i = 1; i < 10; i++) begin
            @(posedge clock); #1;
            udp_sink_ready = pat[i];
        end
        udp_sink_ready = 1'b1;
        wait_idle(50);
        m_sent = m_sent + 16'd1;
        checks++;
        if (vcnt - v0 !== 10) begin
            errors++;
            $display("FAIL bp_valid_cycles: got %0d expected 10", vcnt - v0);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        push_pkt(32'h0A000002, 16'h5001, m_sent,         status_flags, frame_count, rx_packet_count);
        push_pkt(32'h0A000003, 16'h5002, m_sent + 16'd1, status_flags, frame_count, rx_packet_count);
        v0 = vcnt;
        pulse_req(32'h0A000002, 16'h5001);
        repeat (3) begin
            @(posedge clock); #1;
        end
        // Sampled on the same edge that accepts the last beat
        req      = 1'b1;
        req_ip   = 32'h0A000003;
        req_port = 16'h5002;
        @(posedge clock); #1;
        req = 1'b0;
        checks++;
        if (busy !== 1'b0 || udp_sink_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b valid=%b, expected 0 0", busy, udp_sink_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (udp_sink_valid !== 1'b1 || udp_sink_data !== MAGIC) begin
            errors++;
            $display("FAIL b2b_restart: valid=%b data=%h, expected 1 %h", udp_sink_valid, udp_sink_data, MAGIC);
        end
        wait_idle(50);
        m_sent = m_sent + 16'd2;
        checks++;
        if (vcnt - v0 !== 8 || sent_count !== m_sent) begin
            errors++;
            $display("FAIL b2b_totals: valid_cycles=%0d sent=%0d, expected 8 %0d", vcnt - v0, sent_count, m_sent);
        end
    endtask

    task automatic test_coalesce;
        int v0;
        push_pkt(32'hC0A80010, 16'h0010, m_sent,         status_flags, frame_count, rx_packet_count);
        push_pkt(32'hC0A80033, 16'h0003, m_sent + 16'd1, status_flags, frame_count, rx_packet_count);
        v0 = vcnt;
        pulse_req(32'hC0A80010, 16'h0010);
        req = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            req_port = 16'(p);
            req_ip   = 32'hC0A80000 + 32'(p * 17);
            @(posedge clock); #1;
        end
        req = 1'b0;
        wait_idle(60);
        repeat (10) @(negedge clock);
        m_sent = m_sent + 16'd2;
        checks++;
        if (vcnt - v0 !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_count: valid_cycles=%0d busy=%b, expected 8 0", vcnt - v0, busy);
        end
        checks++;
        if (sent_count !== m_sent) begin
            errors++;
            $display("FAIL coalesce_sent: got %0d expected %0d", sent_count, m_sent);
        end
    endtask

    task automatic test_snapshot;
        frame_count     = 32'd5;
        rx_packet_count = 32'd700;
        status_flags    = 16'h0001;
        push_pkt(32'h0A0000FE, 16'h2222, m_sent, 16'h0001, 32'd5, 32'd700);
        pulse_req(32'h0A0000FE, 16'h2222);
        frame_count     = 32'd9;
        rx_packet_count = 32'd701;
        status_flags    = 16'h8000;
        wait_idle(50);
        m_sent = m_sent + 16'd1;
    endtask

    task automatic test_reset_mid;
        int v0;
        exp_q.push_back('{data: MAGIC, last: 1'b0, port: 16'h3333, ip: 32'h0A000033});
        exp_q.push_back('{data: {m_sent, status_flags}, last: 1'b0, port: 16'h3333, ip: 32'h0A000033});
        pulse_req(32'h0A000033, 16'h3333);
        req      = 1'b1;                 // lands in pending
        req_ip   = 32'h0A000044;
        req_port = 16'h4444;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;            // second beat accepted on this edge
        udp_sink_ready = 1'b0;
        reset          = 1'b1;
        @(posedge clock); #1;
        reset          = 1'b0;
        udp_sink_ready = 1'b1;
        checks++;
        if (udp_sink_valid !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b busy=%b sent=%0d, expected 0 0 0", udp_sink_valid, busy, sent_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_beats: %0d of first 2 beats not seen", exp_q.size());
            exp_q.delete();
        end
        m_sent = 16'd0;
        v0 = vcnt;
        repeat (12) @(negedge clock);
        checks++;
        if (vcnt - v0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pending: valid_cycles=%0d busy=%b, expected 0 0", vcnt - v0, busy);
        end
        push_pkt(32'h0A000055, 16'h5555, m_sent, status_flags, frame_count, rx_packet_count);
        pulse_req(32'h0A000055, 16'h5555);
        wait_idle(50);
        m_sent = m_sent + 16'd1;
        checks++;
        if (sent_count !== m_sent) begin
            errors++;
            $display("FAIL midreset_after: sent=%0d expected %0d", sent_count, m_sent);
        end
    endtask

    task automatic test_wrap;
        @(posedge clock); #1;
        force dut.sent_count_q = 16'hFFFF;
        @(posedge clock); #1;
        release dut.sent_count_q;
        @(posedge clock); #1;
        m_sent = 16'hFFFF;
        checks++;
        if (sent_count !== m_sent) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected FFFF", sent_count);
        end
        push_pkt(32'h0A000066, 16'h6666, m_sent, status_flags, frame_count, rx_packet_count);
        pulse_req(32'h0A000066, 16'h6666);
        wait_idle(50);
        m_sent = m_sent + 16'd1;
        checks++;
        if (sent_count !== 16'h0000 || m_sent !== sent_count) begin
            errors++;
            $display("FAIL wrap_sent: got %h expected 0000", sent_count);
        end
    endtask

    initial begin
        reset           = 1'b1;
        req             = 1'b0;
        req_ip          = '0;
        req_port        = '0;
        frame_count     = '0;
        rx_packet_count = '0;
        status_flags    = '0;
        udp_sink_ready  = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_coalesce();
        test_snapshot();
        test_reset_mid();
        test_wrap();
        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
